// File: rtl/sc_dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, port ids and the read-latency range.
package sc_dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Out-of-range latencies are pinned to the nearest legal value.
  function automatic logic [2:0] lat_load(int lat);
    if (lat < RD_LAT_MIN) return 3'(RD_LAT_MIN);
    if (lat > RD_LAT_MAX) return 3'(RD_LAT_MAX);
    return 3'(lat);
  endfunction

endpackage

// File: rtl/sc_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// req[0]=A, req[1]=B; last_grant = id granted last; grant one-hot.
module sc_rr_arb2
  import sc_dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (fixed_prio || last_grant == PORT_B)
          grant = 2'b01;
        else
          grant = 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Shares one data-memory port between A (CPU) and B (DMA/debug).
// Ports: a_*/b_* req/ack requesters, m_* memory side, busy.
module sc_dmem_arbiter
  import sc_dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_LD = lat_load(RD_LAT);

  state_t        state;
  state_t        state_nx;
  logic [2:0]    cnt;
  logic          lat_id;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          last_grant;
  logic [1:0]    req_v;
  logic [1:0]    grant;
  logic          last_wait;

  assign req_v = {b_req, a_req};

  sc_rr_arb2 u_arb (
    .req       (req_v),
    .last_grant(last_grant),
    .fixed_prio(FIXED_PRIO != 0),
    .grant     (grant)
  );

  // Final WAIT cycle: memory data is valid now.
  assign last_wait = (state == WAIT) && (cnt == 3'd1);

  always_comb begin
    state_nx = state;
    m_en     = 1'b0;
    m_we     = 1'b0;
    a_ack    = 1'b0;
    b_ack    = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (|req_v) state_nx = ISSUE;
      end
      ISSUE: begin
        m_en     = 1'b1;
        m_we     = lat_we;
        state_nx = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (last_wait) state_nx = RESP;
      end
      RESP: begin
        a_ack    = (lat_id == PORT_A);
        b_ack    = (lat_id == PORT_B);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Latched transaction; also drives the memory side so
  // m_addr/m_wdata hold their last values between accesses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_id     <= PORT_A;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      last_grant <= PORT_B;
    end else if (state == IDLE && |grant) begin
      lat_id     <= grant[1] ? PORT_B : PORT_A;
      lat_we     <= grant[1] ? b_we : a_we;
      lat_addr   <= grant[1] ? b_addr : a_addr;
      lat_wdata  <= grant[1] ? b_wdata : a_wdata;
      last_grant <= grant[1] ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (state == ISSUE)
      cnt <= LAT_LD;
    else if (state == WAIT)
      cnt <= cnt - 3'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (last_wait) begin
      if (lat_id == PORT_B) b_rdata <= m_rdata;
      else                  a_rdata <= m_rdata;
    end
  end

  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;

endmodule
